// File: rtl/wb_trace_pkg.sv
// Shared record layout for the write-back trace capture block.
package wb_trace_pkg;

    localparam int PC_W    = 32;
    localparam int WNUM_W  = 5;
    localparam int WDATA_W = 32;
    localparam int REC_W   = PC_W + WNUM_W + WDATA_W;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [WNUM_W-1:0]  wnum;
        logic [WDATA_W-1:0] wdata;
    } trace_rec_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// DEPTH-entry synchronous first-word-fall-through FIFO for trace records.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [REC_W-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [REC_W-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_trace_capture.sv
// Captures retiring register writes into a FWFT trace FIFO with sticky overflow.
// Build option: define WB_TRACE_DROP_CNT_EN to add the saturating dropped-event counter.
module wb_trace_capture
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            debug_wb_pc,
    input  logic [3:0]             debug_wb_rf_wen,
    input  logic [4:0]             debug_wb_rf_wnum,
    input  logic [31:0]            debug_wb_rf_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [4:0]             out_wnum,
    output logic [31:0]            out_wdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clear,
    output logic [CNT_W-1:0]       drop_count
);

    trace_rec_t       wr_rec, head_rec;
    logic [REC_W-1:0] head_bits;
    logic             wb_event, pop_req, fifo_empty, fifo_full, drop;
    logic             overflow_q, overflow_d;

    assign wb_event = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);

    assign wr_rec.pc    = debug_wb_pc;
    assign wr_rec.wnum  = debug_wb_rf_wnum;
    assign wr_rec.wdata = debug_wb_rf_wdata;

    // Handshake: a record transfers on a rising edge where out_valid && out_ready;
    // the head holds steady while out_valid && !out_ready, and out_ready is ignored when empty.
    assign out_valid = !fifo_empty;
    assign pop_req   = out_valid && out_ready;
    assign drop      = wb_event && fifo_full && !pop_req;

    wb_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (wb_event),
        .wdata_i (wr_rec),
        .pop_i   (pop_req),
        .rdata_o (head_bits),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level)
    );

    assign head_rec  = trace_rec_t'(head_bits);
    assign out_pc    = head_rec.pc;
    assign out_wnum  = head_rec.wnum;
    assign out_wdata = head_rec.wdata;

    assign overflow_d = clear ? 1'b0 : (overflow_q | drop);
    assign overflow   = overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

`ifdef WB_TRACE_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

endmodule
